// File: rtl/ofm_pool_pkg.sv
// ofm_pool_pkg: shared state type, default widths and saturation helper for the OFM requant/max-pool stage
package ofm_pool_pkg;
    typedef enum logic [1:0] {IDLE, ROW0, ROWN, DISCARD} state_e;
    localparam int IN_W_DEF = 36;
    localparam int OUT_W_DEF = 16;
    function automatic logic [63:0] out_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/ofm_requant.sv
// ofm_requant: right-shift requantiser with saturation; OFM_POOL_ROUND_EN adds round-half-up before the shift
module ofm_requant
    import ofm_pool_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 8
) (
    input  logic [IN_W-1:0]  d_i,
    output logic [OUT_W-1:0] q_o
);
`ifdef OFM_POOL_ROUND_EN
    localparam logic [IN_W:0] RND = (SHIFT == 0) ? '0 : (IN_W+1)'(1) << (SHIFT == 0 ? 0 : SHIFT - 1);
`else
    localparam logic [IN_W:0] RND = '0;
`endif
    localparam logic [63:0] MAX = out_max(OUT_W);
    logic [IN_W:0] sum;
    logic [IN_W:0] shifted;
    // One extra bit keeps the rounding add from wrapping before the shift and clamp
    always_comb begin
        sum = {1'b0, d_i} + RND;
        shifted = sum >> SHIFT;
        q_o = (64'(shifted) > MAX) ? OUT_W'(MAX) : shifted[OUT_W-1:0];
    end
endmodule

// File: rtl/ofm_requant_maxpool.sv
// ofm_requant_maxpool: requantises the conv OFM stream and applies a 2x2 stride-1 max-pool per DIMxDIM frame
module ofm_requant_maxpool
    import ofm_pool_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 8,
    parameter int DIM   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  In_OFM,
    output logic             out_valid,
    output logic [OUT_W-1:0] Out_Pool,
    output logic             frame_done
);
    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);
    state_e state_q, state_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [OUT_W-1:0] prev_q [DIM];
    logic [OUT_W-1:0] prev_d [DIM];
    logic [OUT_W-1:0] cur_q [DIM];
    logic [OUT_W-1:0] cur_d [DIM];
    logic [OUT_W-1:0] q, m0, m1, p, out_q;
    logic accept, last_col, last_row, pool, out_valid_q, frame_done_q;

    ofm_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_requant (.d_i(In_OFM), .q_o(q));

    assign accept   = in_valid && state_q != DISCARD;
    assign last_col = col_q == LAST;
    assign last_row = row_q == LAST;
    assign pool     = accept && row_q != '0 && col_q != '0;

    // Frame FSM and raster counters; any gap in in_valid drops back to IDLE at (0,0)
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? ROW0 : IDLE;
            ROW0:    state_d = !in_valid ? IDLE : last_col ? ROWN : ROW0;
            ROWN:    state_d = !in_valid ? IDLE : (last_col && last_row) ? DISCARD : ROWN;
            default: state_d = in_valid ? DISCARD : IDLE;
        endcase
        col_d = !in_valid ? '0 : !accept ? col_q : last_col ? '0 : col_q + CW'(1);
        row_d = !in_valid ? '0 : (accept && last_col) ? row_q + CW'(1) : row_q;
    end

    // Line buffers: current row written per beat, rolled into prev_row including the wrap beat
    always_comb begin
        cur_d = cur_q;
        if (accept) cur_d[col_q] = q;
        prev_d = prev_q;
        if (accept && last_col) prev_d = cur_d;
    end

    // 2x2 window max; the live beat is used directly rather than read back from cur_row
    always_comb begin
        m0 = (prev_q[col_q - CW'(1)] > prev_q[col_q]) ? prev_q[col_q - CW'(1)] : prev_q[col_q];
        m1 = (cur_q[col_q - CW'(1)] > q) ? cur_q[col_q - CW'(1)] : q;
        p  = (m0 > m1) ? m0 : m1;
    end

    // State, counters, line buffers and the registered pooled output
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            prev_q       <= '{default: '0};
            cur_q        <= '{default: '0};
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            out_valid_q  <= pool;
            out_q        <= pool ? p : '0;
            frame_done_q <= pool && last_col && last_row;
        end
    end

    assign out_valid  = out_valid_q;
    assign Out_Pool   = out_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ofm_requant_maxpool.sv
// tb_ofm_requant_maxpool: table-driven frame vectors plus mid-frame reset sequence
module tb_ofm_requant_maxpool;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [35:0] In_OFM = '0;
    logic        out_valid;
    logic [15:0] Out_Pool;
    logic        frame_done;
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [15:0] obs_v[$];
    logic        obs_d[$];
    int          obs_c[$];

    typedef struct {
        string       name;
        int          nb;
        logic [35:0] b [12];
        int          ne;
        logic [15:0] ev [4];
        int          eb [4];
        bit          done;
    } vec_t;
    vec_t vt [8];

`ifdef OFM_POOL_ROUND_EN
    localparam logic [15:0] R384 = 16'd2;
`else
    localparam logic [15:0] R384 = 16'd1;
`endif

    ofm_requant_maxpool dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .In_OFM(In_OFM),
        .out_valid(out_valid), .Out_Pool(Out_Pool), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                obs_v.push_back(Out_Pool);
                obs_d.push_back(frame_done);
                obs_c.push_back(cyc);
            end else begin
                chk("idle_out_zero", {Out_Pool, frame_done}, 17'd0);
            end
        end
    end

    function automatic vec_t mk(input string n, input int nb, input int ne, input bit d);
        vec_t v;
        v.name = n;
        v.nb = nb;
        v.ne = ne;
        v.done = d;
        for (int i = 0; i < 12; i++) v.b[i] = '0;
        for (int i = 0; i < 4; i++) begin
            v.ev[i] = '0;
            v.eb[i] = 0;
        end
        return v;
    endfunction

    function automatic vec_t full(input string n, input logic [15:0] e0, input logic [15:0] e1,
                                  input logic [15:0] e2, input logic [15:0] e3);
        vec_t v = mk(n, 9, 4, 1'b1);
        v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2; v.ev[3] = e3;
        v.eb[0] = 5;  v.eb[1] = 6;  v.eb[2] = 8;  v.eb[3] = 9;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int s;
        s = 0;
        obs_v.delete();
        obs_d.delete();
        obs_c.delete();
        for (int k = 0; k < v.nb; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            In_OFM = v.b[k];
            if (k == 0) s = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        In_OFM = '0;
        @(negedge clk);
        #1;
        chk({v.name, "_count"}, obs_v.size(), v.ne);
        for (int i = 0; i < v.ne && i < obs_v.size(); i++) begin
            chk($sformatf("%s_val%0d", v.name, i), obs_v[i], v.ev[i]);
            chk($sformatf("%s_beat%0d", v.name, i), obs_c[i] - s, v.eb[i]);
            chk($sformatf("%s_done%0d", v.name, i), obs_d[i], v.done && i == v.ne - 1);
        end
    endtask

    initial begin
        vt[0] = full("ramp", 16'd5, 16'd6, 16'd8, 16'd9);
        for (int k = 0; k < 9; k++) vt[0].b[k] = 36'(256 * (k + 1));
        vt[1] = mk("short", 6, 2, 1'b0);
        for (int k = 0; k < 6; k++) vt[1].b[k] = 36'(256 * (k + 1));
        vt[1].ev[0] = 16'd5; vt[1].ev[1] = 16'd6; vt[1].eb[0] = 5; vt[1].eb[1] = 6;
        vt[2] = full("sat", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 9; k++) vt[2].b[k] = 36'hF_FFFF_FFFF;
        vt[3] = full("r384", R384, R384, R384, R384);
        for (int k = 0; k < 9; k++) vt[3].b[k] = 36'd384;
        vt[4] = full("r383", 16'd1, 16'd1, 16'd1, 16'd1);
        for (int k = 0; k < 9; k++) vt[4].b[k] = 36'd383;
        vt[5] = full("long", 16'd5, 16'd6, 16'd8, 16'd9);
        vt[5].nb = 12;
        for (int k = 0; k < 9; k++) vt[5].b[k] = 36'(256 * (k + 1));
        for (int k = 9; k < 12; k++) vt[5].b[k] = 36'hFFFF00;
        vt[6] = full("desc", 16'd9, 16'd8, 16'd6, 16'd5);
        for (int k = 0; k < 9; k++) vt[6].b[k] = 36'(256 * (9 - k));
        vt[7] = full("mixed", 16'd9, 16'd2, 16'd9, 16'd1);
        for (int k = 0; k < 9; k++) vt[7].b[k] = 36'd256;
        vt[7].b[1] = 36'd512;
        vt[7].b[3] = 36'd2304;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pool", Out_Pool, 16'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        mon_en = 1'b1;
        #1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        obs_v.delete();
        obs_d.delete();
        obs_c.delete();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            In_OFM = 36'(256 * (k + 1));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        In_OFM = 36'(256 * 5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        In_OFM = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_output", obs_v.size(), 0);
        run_vec(vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
